// File: rtl/riscv_dmem_responder.sv
// ---------------------------------------------------------------------------
// riscv_dmem_responder
//   Target end of the core's load/store port. Accepts one word LW/SW request
//   per handshake, performs it after a fixed access latency and returns the
//   read data (or an error flag) through a second handshake.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. req_ready depends only on the
// FSM state (high in IDLE). Once rsp_valid is high, rsp_valid, rsp_rdata and
// rsp_err stay unchanged until the edge on which rsp_ready is also high.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_addr              byte address (word index = req_addr[ADDR_W-1:2])
//   req_wdata/req_wstrb   store data and byte-lane enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data, 0 for stores and errors
//   rsp_err               misaligned or out-of-range access
//
// Internal state (state_q, cnt_q) is kept under stable names for probing.
// ---------------------------------------------------------------------------
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 2     // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = 4;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Storage is deliberately not reset; contents survive a reset.
  logic [31:0]         mem_q [DEPTH_WORDS];

  logic [ADDR_W-3:0]   word_idx;
  logic [IDX_W-1:0]    mem_idx;
  logic                acc_err;
  logic                acc_fire;
  logic                mem_we;

  // Access decode always uses the latched request, never the live inputs.
  assign word_idx = addr_q[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_LIM);

  // Every request passes through WAIT, even with LATENCY==1: the counter is
  // loaded with LATENCY-1 at accept and the access fires on the edge where
  // it has reached zero, so rsp_valid rises exactly LATENCY edges after the
  // accept edge.
  assign acc_fire = (state_q == ST_WAIT) && (cnt_q == '0);

  // Reset has priority over a pending store, so an uncommitted store is lost.
  assign mem_we = acc_fire && we_q && !acc_err && !reset;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (acc_fire) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (!we_q && !acc_err) ? mem_q[mem_idx] : 32'h0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane store commit on the access edge; disabled lanes keep old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
